// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: datapath widths, special instruction encodings and
// the IF/ID pipeline-register control encoding.
package instr_fetch_pkg;

  localparam int unsigned AddrWidth  = 16;
  localparam int unsigned InstrWidth = 32;

  localparam logic [InstrWidth-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [InstrWidth-1:0] HALT_INSTR = 32'hD600_03E0;  // BR XZR

  typedef enum logic [1:0] {
    CtlHold,
    CtlLoad,
    CtlBubble
  } if_id_ctl_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, inserts a bubble, or holds.
// Reset and bubble both leave NOP at pc 0 with valid cleared.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [AddrWidth-1:0]  pc_in,
  input  logic [InstrWidth-1:0] instr_in,
  output logic [AddrWidth-1:0]  pc,
  output logic [InstrWidth-1:0] instr,
  output logic                  valid
);

  logic [AddrWidth-1:0]  pc_q, pc_d;
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  if_id_ctl_e            ctl;

  always_comb begin
    ctl = CtlHold;
    if (bubble) begin
      ctl = CtlBubble;
    end else if (load) begin
      ctl = CtlLoad;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (ctl)
      CtlLoad: begin
        pc_d    = pc_in;
        instr_d = instr_in;
        valid_d = 1'b1;
      end
      CtlBubble: begin
        pc_d    = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, redirect/stall priority and optional halt
// detection (enabled by defining FETCH_HALT_DETECT_EN).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [AddrWidth-1:0]  branch_target,
  output logic [AddrWidth-1:0]  imem_addr,
  input  logic [InstrWidth-1:0] imem_data,
  output logic [AddrWidth-1:0]  if_id_pc,
  output logic [InstrWidth-1:0] if_id_instr,
  output logic                  if_id_valid,
  output logic                  halted
);

  logic [AddrWidth-1:0] pc_q, pc_d;
  logic                 load, bubble;
  logic                 halted_q;
`ifdef FETCH_HALT_DETECT_EN
  logic                 halt_set;
`endif

  always_comb begin
    pc_d   = pc_q;
    load   = 1'b0;
    bubble = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    halt_set = 1'b0;
`endif
    if (halted_q) begin
      bubble = 1'b1;
    end else if (branch_taken) begin
      // Redirect wins over stall; the wrong-path word is dropped.
      pc_d   = branch_target;
      bubble = 1'b1;
    end else if (!stall) begin
      load = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
      if (imem_data == HALT_INSTR) begin
        halt_set = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
`else
      pc_d = pc_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (halt_set) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bubble   (bubble),
    .pc_in    (pc_q),
    .instr_in (imem_data),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a reference model feeding a scoreboard queue.
// A second instance checks the RESET_PC=16'hFFFF wrap case.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [15:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [15:0] branch_target, imem_addr, if_id_pc;
  logic [31:0] imem_data, if_id_instr;
  logic        if_id_valid, halted;

  logic        rst2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        branch_taken2 = 1'b0;
  logic [15:0] branch_target2 = 16'h0000;
  logic [15:0] imem_addr2, if_id_pc2;
  logic [31:0] imem_data2, if_id_instr2;
  logic        if_id_valid2, halted2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exp_t        sb[$];
  logic [15:0] m_pc;
  logic        m_halted;
  exp_t        m_last;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    logic [31:0] w;
    case (a)
      16'd0: w = 32'hA000_00A0;
      16'd1: w = 32'hA000_00A1;
      16'd2: w = 32'hA000_00A2;
      16'd3: w = 32'hA000_00A3;
      16'd4: w = 32'hD600_03E0;
      default: w = {16'h5A5A, a};
    endcase
    return w;
  endfunction

  assign imem_data  = rom(imem_addr);
  assign imem_data2 = rom(imem_addr2);

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk           (clk),
    .rst           (rst2),
    .stall         (stall2),
    .branch_taken  (branch_taken2),
    .branch_target (branch_target2),
    .imem_addr     (imem_addr2),
    .imem_data     (imem_data2),
    .if_id_pc      (if_id_pc2),
    .if_id_instr   (if_id_instr2),
    .if_id_valid   (if_id_valid2),
    .halted        (halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict the post-edge state, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    e = '0;
    if (r) begin
      m_pc = 16'h0000; m_halted = 1'b0;
      e.instr = NOP_INSTR;
    end else if (m_halted) begin
      e.instr = NOP_INSTR;
    end else if (b) begin
      m_pc = t;
      e.instr = NOP_INSTR;
    end else if (s) begin
      e = m_last;
    end else begin
      e.pc = m_pc; e.instr = rom(m_pc); e.valid = 1'b1;
      if (HaltEn && rom(m_pc) == 32'hD600_03E0) m_halted = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
    e.halted = m_halted;
    e.addr   = m_pc;
    m_last   = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("if_id_pc", {16'h0, if_id_pc}, {16'h0, e.pc});
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
      chk("halted", {31'h0, halted}, {31'h0, e.halted});
      chk("imem_addr", {16'h0, imem_addr}, {16'h0, e.addr});
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    m_last = '0;

    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("reset_valid", {31'h0, if_id_valid}, 32'h0);
    chk("reset_instr", if_id_instr, 32'h0);

    step(0, 0, 0, 16'h0);
    chk("first_fetch_instr", if_id_instr, 32'hA000_00A0);
    step(0, 0, 0, 16'h0);

    // Hold while PC=2 for two cycles.
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    chk("stall_addr", {16'h0, imem_addr}, 32'd2);
    chk("stall_hold_pc", {16'h0, if_id_pc}, 32'd1);
    step(0, 0, 0, 16'h0);
    chk("after_stall_pc", {16'h0, if_id_pc}, 32'd2);

    // Redirect together with stall at PC=3.
    step(0, 1, 1, 16'h0010);
    chk("branch_bubble_valid", {31'h0, if_id_valid}, 32'h0);
    chk("branch_bubble_instr", if_id_instr, 32'h0);
    step(0, 0, 0, 16'h0);
    chk("branch_target_pc", {16'h0, if_id_pc}, 32'h10);
    step(0, 0, 0, 16'h0);

    // Reset overrides a stall and a redirect.
    step(1, 1, 0, 16'h0);
    step(1, 0, 1, 16'h0030);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0);
    chk("halt_word_pc", {16'h0, if_id_pc}, 32'd4);
    chk("halt_addr", {16'h0, imem_addr}, HaltEn ? 32'd4 : 32'd5);
    chk("halt_flag", {31'h0, halted}, {31'h0, HaltEn});

    step(0, 0, 1, 16'h0020);
    step(0, 1, 1, 16'h0020);
    step(0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0);

    // Reset while possibly halted, then fetch resumes at 0.
    step(1, 0, 1, 16'h0040);
    chk("halt_cleared", {31'h0, halted}, 32'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);

    // Wrap instance: first fetch at 16'hFFFF, then 16'h0000.
    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_first_pc", {16'h0, if_id_pc2}, 32'h0000_FFFF);
    chk("wrap_first_valid", {31'h0, if_id_valid2}, 32'h1);
    @(posedge clk);
    #1;
    chk("wrap_second_pc", {16'h0, if_id_pc2}, 32'h0);
    chk("wrap_second_instr", if_id_instr2, 32'hA000_00A0);
    chk("wrap_addr", {16'h0, imem_addr2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the instruction word address loaded into the PC on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  hazard unit hold: freeze PC and IF/ID register.
REQ-005 SHALL have port branch_taken  input  1  redirect request from a later stage.
REQ-006 SHALL have port branch_target  input  16  word address to redirect to.
REQ-007 SHALL have port imem_addr  output  16  word address to the instruction ROM.
REQ-008 SHALL have port imem_data  input  32  combinational ROM read data for imem_addr.
REQ-009 SHALL have port if_id_pc  output  16  PC of the instruction held in IF/ID.
REQ-010 SHALL have port if_id_instr  output  32  instruction held in IF/ID.
REQ-011 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-012 SHALL have port halted  output  1  fetch stopped on the halt instruction.

Function
REQ-013 SHALL drive imem_addr combinationally from the PC register; the PC is word-indexed and advances by 1 per instruction.
REQ-014 SHALL apply update priority per edge: rst > halted > branch_taken > stall > normal fetch.
REQ-015 Normal fetch SHALL load IF/ID with {PC, imem_data, valid=1} and set PC <= PC+1, so one-cycle latency from address to if_id_instr.
REQ-016 PC increment SHALL be 16-bit modulo: 16'hFFFF advances to 16'h0000 with no flag.
REQ-017 On branch_taken, PC SHALL load branch_target and IF/ID SHALL load a bubble (valid=0, instr=NOP_INSTR, pc=0); the wrong-path word is discarded.
REQ-018 branch_taken together with stall SHALL behave exactly as branch_taken alone.
REQ-019 On stall without branch_taken, PC and all IF/ID outputs SHALL hold their values.
REQ-020 Bubble outputs SHALL be if_id_instr=NOP_INSTR (32'h00000000) and if_id_pc=16'h0000.

Reset
REQ-021 On rst, at the clock edge: PC=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=16'h0000, halted=0.
REQ-022 rst asserted mid-stall, mid-redirect or while halted SHALL override everything; the first fetch from RESET_PC SHALL occur on the first edge with rst=0.

Configuration
REQ-023 Macro FETCH_HALT_DETECT_EN SHALL enable halt detection: on a normal-fetch edge with imem_data==HALT_INSTR (32'hD60003E0, BR XZR), IF/ID SHALL take that instruction with valid=1, PC SHALL NOT advance, and halted SHALL be 1 from that edge on.
REQ-024 With FETCH_HALT_DETECT_EN defined: while halted=1, PC SHALL be frozen, IF/ID SHALL load a bubble each edge, branch_taken and stall SHALL be ignored, and only rst SHALL clear halted.
REQ-025 Without FETCH_HALT_DETECT_EN: halted SHALL be tied 0 and HALT_INSTR SHALL be fetched like any other word.

Structure
REQ-026 SHALL take NOP_INSTR, HALT_INSTR, and the 16-bit address and 32-bit instruction widths from the shared processor package.
REQ-027 SHALL be split into instr_fetch (PC, priority, halt control) and one sub-module if_id_reg holding the pipeline register with load/bubble/hold controls.

Verification
REQ-028 Reset then release, ROM words A0..A3 at 0..3, no stall -> if_id_pc 0,1,2,3 on successive edges, if_id_valid=1, instr matches.
REQ-029 stall=1 for 2 cycles while PC=2 -> imem_addr stays 2, IF/ID holds pc=1 for 2 cycles, then pc=2 is delivered.
REQ-030 branch_taken=1 with stall=1 and branch_target=16'h0010 at PC=3 -> next edge valid=0, instr=0; following edge if_id_pc=16'h0010.
REQ-031 RESET_PC=16'hFFFF -> if_id_pc sequence 16'hFFFF, 16'h0000.
REQ-032 FETCH_HALT_DETECT_EN on, ROM address 4 returns 32'hD60003E0 -> IF/ID pc=4 valid=1, then halted=1 and bubbles, imem_addr held at 4 despite branch_taken=1; rst clears halted.
REQ-033 FETCH_HALT_DETECT_EN off, same program -> halted stays 0, PC advances to 5.
